serial_magnitude_comparator: RTL and testbench

Parametrised, multi-cycle magnitude comparator that is the successor to the fixed 4-bit combinational comparator. It compares two WIDTH-bit operands DIGIT bits per cycle, MSB-first, in signed or unsigned mode, behind a start/busy/done handshake. It sits in datapaths where wide operands make a single-cycle comparator too slow or too large, and where results are consumed by a sequential controller.

---
 rtl/serial_magnitude_comparator.sv | 186 ++++++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
// Multi-cycle magnitude comparator. Compares two WIDTH-bit operands DIGIT bits
// per cycle, MSB-first, in signed or unsigned mode, behind a start/busy/done
// handshake. Results are registered and hold until the next done pulse.
//
// Build option: SERIAL_CMP_EARLY_EXIT_EN
//   defined   - stop on the first differing digit (latency 1..NDIG cycles)
//   undefined - always step all NDIG digits, remembering the first difference
//               in a sticky flag (constant latency of NDIG cycles)
//
// state | meaning
// IDLE  | waiting for start; result outputs hold the last completed comparison
// CMP   | stepping through operand digits, one digit pair per cycle
module serial_magnitude_comparator #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             is_signed,
    output logic             busy,
    output logic             done,
    output logic             greater,
    output logic             equal,
    output logic             less
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0]    LAST_DIG = CW'(NDIG - 1);
    localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

    generate
        if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_cfg
            $error("serial_magnitude_comparator: WIDTH must be a multiple of DIGIT");
        end
    endgenerate

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] sh_a;
    logic [WIDTH-1:0] sh_b;
    logic             sgn;
    logic [CW-1:0]    cnt;

    logic [DIGIT-1:0] dig_a;
    logic [DIGIT-1:0] dig_b;
    logic             dig_gt;
    logic             dig_lt;
    logic             last_dig;

    logic             load;
    logic             finish;
    logic             res_gt;
    logic             res_lt;

`ifndef SERIAL_CMP_EARLY_EXIT_EN
    logic             diff_seen;
    logic             diff_gt;
`endif

    // Current digit pair; in signed mode the MSB digit gets its sign bit
    // flipped so an unsigned compare orders two's-complement values correctly.
    always_comb begin
        dig_a = sh_a[WIDTH-1 -: DIGIT];
        dig_b = sh_b[WIDTH-1 -: DIGIT];
        if (sgn && (cnt == '0)) begin
            dig_a = dig_a ^ MSB_MASK;
            dig_b = dig_b ^ MSB_MASK;
        end
        dig_gt   = (dig_a > dig_b);
        dig_lt   = (dig_a < dig_b);
        last_dig = (cnt == LAST_DIG);
    end

    // Next-state and completion decode.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        finish    = 1'b0;
        res_gt    = 1'b0;
        res_lt    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    state_nxt = CMP;
                end
            end
            CMP: begin
`ifdef SERIAL_CMP_EARLY_EXIT_EN
                // Any earlier difference would already have ended the compare.
                res_gt = dig_gt;
                res_lt = dig_lt;
                finish = dig_gt || dig_lt || last_dig;
`else
                if (diff_seen) begin
                    res_gt = diff_gt;
                    res_lt = !diff_gt;
                end else begin
                    res_gt = dig_gt;
                    res_lt = dig_lt;
                end
                finish = last_dig;
`endif
                if (finish) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand shift registers, captured mode and digit counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_a <= '0;
            sh_b <= '0;
            sgn  <= 1'b0;
            cnt  <= '0;
        end else if (load) begin
            sh_a <= a;
            sh_b <= b;
            sgn  <= is_signed;
            cnt  <= '0;
        end else if (state == CMP) begin
            sh_a <= sh_a << DIGIT;
            sh_b <= sh_b << DIGIT;
            cnt  <= cnt + CW'(1);
        end
    end

`ifndef SERIAL_CMP_EARLY_EXIT_EN
    // Sticky record of the first differing digit pair, so the full-length
    // run still reports the most significant difference.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            diff_seen <= 1'b0;
            diff_gt   <= 1'b0;
        end else if (load) begin
            diff_seen <= 1'b0;
            diff_gt   <= 1'b0;
        end else if ((state == CMP) && !diff_seen && (dig_gt || dig_lt)) begin
            diff_seen <= 1'b1;
            diff_gt   <= dig_gt;
        end
    end
`endif

    // Registered result outputs and one-cycle done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done    <= 1'b0;
            greater <= 1'b0;
            equal   <= 1'b0;
            less    <= 1'b0;
        end else begin
            done <= finish;
            if (finish) begin
                greater <= res_gt;
                less    <= res_lt;
                equal   <= !(res_gt || res_lt);
            end
        end
    end

    assign busy = (state == CMP);

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// Directed bench for serial_magnitude_comparator (16/4 instance) plus a
// strided sweep of an 8/2 instance against a behavioural compare.
module tb_serial_magnitude_comparator;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif
    localparam int NDIG = 4;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic        s;
        logic [2:0]  gel;
        int          lat_ee;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;

    logic        start = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        is_signed = 1'b0;
    logic        busy, done, greater, equal, less;

    logic        start8 = 1'b0;
    logic [7:0]  a8 = '0;
    logic [7:0]  b8 = '0;
    logic        s8 = 1'b0;
    logic        busy8, done8, g8, e8, l8;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(16), .DIGIT(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
        .is_signed(is_signed), .busy(busy), .done(done),
        .greater(greater), .equal(equal), .less(less)
    );

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8),
        .is_signed(s8), .busy(busy8), .done(done8),
        .greater(g8), .equal(e8), .less(l8)
    );

    // Waits (bounded) for done on the 16-bit instance; lat = -1 on timeout.
    task automatic wait_done(output int lat);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done !== 1'b1) lat = -1;
    endtask

    task automatic run_cmp(input logic [15:0] aa, input logic [15:0] bb,
                           input logic s, output int lat);
        @(negedge clk);
        a = aa; b = bb; is_signed = s; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat);
    endtask

    task automatic run_cmp8(input logic [7:0] aa, input logic [7:0] bb,
                            input logic s, output int lat);
        @(negedge clk);
        a8 = aa; b8 = bb; s8 = s; start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        if (done8 !== 1'b1) lat = -1;
    endtask

    task automatic test_reset();
        int lat;
        bit seen;
        #3 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({busy, done, greater, equal, less} !== 5'b0)
            $display("FAIL reset_init: got bdgel=%b expected 00000", {busy, done, greater, equal, less});
        else pass_cnt++;
        rst_n = 1'b1;
        run_cmp(16'h8000, 16'h7FFF, 1'b0, lat);
        total_cnt++;
        if ({greater, equal, less} !== 3'b100)
            $display("FAIL reset_pre_result: got gel=%b expected 100", {greater, equal, less});
        else pass_cnt++;
        @(negedge clk);
        a = 16'h1234; b = 16'h1235; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        total_cnt++;
        if (busy !== 1'b1)
            $display("FAIL reset_busy_mid: got busy=%b expected 1", busy);
        else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, done, greater, equal, less} !== 5'b0)
            $display("FAIL reset_mid: got bdgel=%b expected 00000", {busy, done, greater, equal, less});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
        end
        total_cnt++;
        if (seen !== 1'b0 || {greater, equal, less} !== 3'b000)
            $display("FAIL reset_no_done_after: got activity=%b gel=%b expected 0 000", seen, {greater, equal, less});
        else pass_cnt++;
    endtask

    task automatic test_unsigned();
        vec_t v[3];
        int lat;
        int exp_lat;
        v[0] = '{16'h8000, 16'h7FFF, 1'b0, 3'b100, 1};
        v[1] = '{16'hFFFF, 16'h0001, 1'b0, 3'b100, 1};
        v[2] = '{16'h0100, 16'h0200, 1'b0, 3'b001, 2};
        for (int i = 0; i < 3; i++) begin
            run_cmp(v[i].a, v[i].b, v[i].s, lat);
            exp_lat = EE ? v[i].lat_ee : NDIG;
            total_cnt++;
            if ({greater, equal, less} !== v[i].gel)
                $display("FAIL unsigned_result[%0d]: got gel=%b expected %b", i, {greater, equal, less}, v[i].gel);
            else pass_cnt++;
            total_cnt++;
            if (lat != exp_lat)
                $display("FAIL unsigned_latency[%0d]: got %0d expected %0d", i, lat, exp_lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_signed();
        vec_t v[4];
        int lat;
        int exp_lat;
        v[0] = '{16'h8000, 16'h7FFF, 1'b1, 3'b001, 1};
        v[1] = '{16'hFFFF, 16'h0001, 1'b1, 3'b001, 1};
        v[2] = '{16'hFFFF, 16'hFFFE, 1'b1, 3'b100, 4};
        v[3] = '{16'h7FFF, 16'h8000, 1'b1, 3'b100, 1};
        for (int i = 0; i < 4; i++) begin
            run_cmp(v[i].a, v[i].b, v[i].s, lat);
            exp_lat = EE ? v[i].lat_ee : NDIG;
            total_cnt++;
            if ({greater, equal, less} !== v[i].gel)
                $display("FAIL signed_result[%0d]: got gel=%b expected %b", i, {greater, equal, less}, v[i].gel);
            else pass_cnt++;
            total_cnt++;
            if (lat != exp_lat)
                $display("FAIL signed_latency[%0d]: got %0d expected %0d", i, lat, exp_lat);
            else pass_cnt++;
        end
    endtask

    task automatic test_equal_late();
        vec_t v[4];
        int lat;
        v[0] = '{16'hA5A5, 16'hA5A5, 1'b0, 3'b010, 4};
        v[1] = '{16'hA5A5, 16'hA5A5, 1'b1, 3'b010, 4};
        v[2] = '{16'h0010, 16'h0011, 1'b0, 3'b001, 4};
        v[3] = '{16'h0000, 16'h0000, 1'b1, 3'b010, 4};
        for (int i = 0; i < 4; i++) begin
            run_cmp(v[i].a, v[i].b, v[i].s, lat);
            total_cnt++;
            if ({greater, equal, less} !== v[i].gel)
                $display("FAIL equal_late_result[%0d]: got gel=%b expected %b", i, {greater, equal, less}, v[i].gel);
            else pass_cnt++;
            total_cnt++;
            if (lat != v[i].lat_ee)
                $display("FAIL equal_late_latency[%0d]: got %0d expected %0d", i, lat, v[i].lat_ee);
            else pass_cnt++;
        end
    endtask

    task automatic test_handshake();
        int lat;
        @(negedge clk);
        a = 16'h0005; b = 16'h0009; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        lat = 0;
        while (done !== 1'b1 && lat < 40) begin
            a = ~a; b = ~b;
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        if (done !== 1'b1) lat = -1;
        total_cnt++;
        if ({greater, equal, less} !== 3'b001)
            $display("FAIL handshake_captured: got gel=%b expected 001", {greater, equal, less});
        else pass_cnt++;
        total_cnt++;
        if (lat != NDIG)
            $display("FAIL handshake_latency: got %0d expected %0d", lat, NDIG);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if ({busy, done} !== 2'b00)
            $display("FAIL handshake_no_queue: got busy,done=%b expected 00", {busy, done});
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int lat;
        int exp_lat;
        run_cmp(16'h1000, 16'h2000, 1'b0, lat);
        exp_lat = EE ? 1 : NDIG;
        total_cnt++;
        if ({greater, equal, less} !== 3'b001 || lat != exp_lat)
            $display("FAIL b2b_first: got gel=%b lat=%0d expected 001 lat=%0d", {greater, equal, less}, lat, exp_lat);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0)
            $display("FAIL b2b_done_busy: got busy=%b expected 0", busy);
        else pass_cnt++;
        a = 16'h0003; b = 16'h0002; is_signed = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        total_cnt++;
        if (busy !== 1'b1)
            $display("FAIL b2b_accept: got busy=%b expected 1", busy);
        else pass_cnt++;
        wait_done(lat);
        total_cnt++;
        if ({greater, equal, less} !== 3'b100 || lat != NDIG)
            $display("FAIL b2b_second: got gel=%b lat=%0d expected 100 lat=%0d", {greater, equal, less}, lat, NDIG);
        else pass_cnt++;
    endtask

    task automatic test_sweep8();
        logic [7:0] edges [5];
        logic [7:0] x, y;
        logic [2:0] exp_gel;
        int lat;
        bit gt, lt;
        edges[0] = 8'h00; edges[1] = 8'h01; edges[2] = 8'h7F;
        edges[3] = 8'h80; edges[4] = 8'hFF;
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 23; i++) begin
                for (int j = 0; j < 21; j++) begin
                    if (i < 18) x = 8'(i * 15); else x = edges[i - 18];
                    if (j < 16) y = 8'(j * 17); else y = edges[j - 16];
                    if (m == 1) begin
                        gt = $signed(x) > $signed(y);
                        lt = $signed(x) < $signed(y);
                    end else begin
                        gt = x > y;
                        lt = x < y;
                    end
                    exp_gel = {gt, !(gt || lt), lt};
                    run_cmp8(x, y, m[0], lat);
                    total_cnt++;
                    if ({g8, e8, l8} !== exp_gel)
                        $display("FAIL sweep8_result a=%h b=%h s=%0d: got gel=%b expected %b", x, y, m, {g8, e8, l8}, exp_gel);
                    else pass_cnt++;
                    total_cnt++;
                    if (EE ? (lat < 1 || lat > NDIG) : (lat != NDIG))
                        $display("FAIL sweep8_latency a=%h b=%h s=%0d: got %0d expected %s", x, y, m, lat, EE ? "1..4" : "4");
                    else pass_cnt++;
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_unsigned();
        test_signed();
        test_equal_late();
        test_handshake();
        test_back_to_back();
        test_sweep8();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
